ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle control state machine that drives the processor-register block. It fetches instructions, decodes them, and sequences execution of the CR16-style datapath. It produces the `pc_en` and `instr_en` strobes and the three flag-group enables, plus register-file and memory controls. It reads back `instr` and `psr` to decode the current instruction and resolve conditional branches and jumps.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes occur on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr` in 16: current instruction register contents.
- `psr` in 16: status register. Flag bits are C[0], L[2], F[5], Z[6], N[7].
- `mem_ready` in 1: memory ready. While low during FETCH or MEM, the FSM holds the current state.
- `instr_en` out 1: load the instruction register from memory read data.
- `pc_en` out 1: load the PC.
- `pc_sel` out 2: PC source. 00 = PC+1, 01 = PC+sign-extended `instr[7:0]`, 10 = Rsrc, 11 = reserved.
- `cmp_f_en`, `of_f_en`, `z_f_en` out 1 each: flag-group enables (L/N, F/C, Z).
- `rf_wr_en` out 1: register-file write enable.
- `wb_sel` out 2: write-back source. 00 = ALU, 01 = memory, 10 = PC+1.
- `mem_rd`, `mem_wr` out 1 each: memory read and write strobes.
- `addr_sel` out 1: memory address source. 0 = PC, 1 = Raddr.
- `illegal` out 1: one-cycle pulse in EXEC for an undecodable instruction.

## Operation
- Instruction fields: op = `instr[15:12]`, ext = `instr[7:4]`, cond = `instr[11:8]`.
- Instruction classes:
  - R-type ALU: op = 0000, ext ∈ {0001, 0010, 0011, 0101, 1001, 1011, 1101}. The all-zero word is NOP.
  - I-type ALU: op ∈ {0001, 0010, 0011, 0101, 1001, 1011, 1101, 1111}.
  - Shifts: op = 1000.
  - LOAD: op = 0100, ext = 0000.
  - STOR: op = 0100, ext = 0100.
  - Jcond: op = 0100, ext = 1100.
  - Bcond: op = 1100.
- Flag enables are asserted only in EXEC:
  - ADD/ADDI/SUB/SUBI: `of_f_en`, `z_f_en`.
  - CMP/CMPI: `cmp_f_en`, `z_f_en`.
  - AND/OR/XOR and their immediates: `z_f_en`.
  - MOV/MOVI/LUI/shifts: none.
- Condition codes (cond → taken when):
  - 0000 Z=1; 0001 Z=0; 0010 C=1; 0011 C=0.
  - 0100 L=1; 0101 L=0; 0110 N=1; 0111 N=0.
  - 1000 F=1; 1001 F=0.
  - 1010 L=0 and Z=0; 1011 L=1 or Z=1.
  - 1100 N=0 and Z=0; 1101 N=1 or Z=1.
  - 1110 always; 1111 never.
- States and transitions:
  - **FETCH**: `addr_sel`=0, `mem_rd`=1. Stays while `mem_ready`=0. Goes to DECODE with `instr_en`=1 on the cycle `mem_ready`=1.
  - **DECODE**: no outputs asserted. Goes to EXEC.
  - **EXEC**, by class:
    - ALU/shift: `rf_wr_en`=1, `wb_sel`=00, flag enables as above; `pc_en`=1, `pc_sel`=00; next FETCH.
    - LOAD/STOR: no PC update; next MEM.
    - Taken branch/jump: `pc_en`=1 with `pc_sel`=01 (Bcond) or 10 (Jcond); next FETCH.
    - Not-taken branch/jump: `pc_en`=1, `pc_sel`=00; next FETCH.
    - Illegal: behaves as NOP (PC+1) and pulses `illegal`.
  - **MEM**: `addr_sel`=1; `mem_rd`=1 (LOAD) or `mem_wr`=1 (STOR). Stays while `mem_ready`=0. On `mem_ready`=1:
    - LOAD: `rf_wr_en`=1, `wb_sel`=01.
    - Both: `pc_en`=1, `pc_sel`=00; next FETCH.
- `instr` and `psr` are sampled combinationally. Flags written in EXEC are first visible to the following instruction.

## Timing
- Reset (asynchronous, any state): state = FETCH.
- During reset and in every state, every output not listed for that state is 0. `pc_sel` and `wb_sel` default to 00; `addr_sel` defaults to 0.
- Latency with `mem_ready` held at 1:
  - ALU, branch, jump: 3 cycles.
  - LOAD/STOR: 4 cycles.
  - Each cycle `mem_ready` is low adds one cycle in FETCH or MEM.
- Outputs are a function of state and inputs only (Mealy on `mem_ready` and the decoded instruction); they are not registered.
- Reset deasserting mid-wait: the FSM restarts in FETCH and no strobe from the aborted instruction is reissued.

## Configuration
- `CTRL_JAL_EN` defined: op = 0100, ext = 1000 decodes as JAL. In EXEC it asserts:
  - `rf_wr_en`=1, `wb_sel`=10 (write PC+1 to Rdest).
  - `pc_en`=1, `pc_sel`=10 (jump to Rsrc).
  - Then goes to FETCH.
- `CTRL_JAL_EN` undefined: that encoding is illegal, executes as NOP, and pulses `illegal`.

## Test plan
- Reset and fetch: hold `reset_n`=0, then release with `mem_ready`=1 → `mem_rd`=1 in the first cycle; `instr_en`=1 in that same cycle; no other strobes.
- ADD: `instr`=0x0152 → EXEC asserts `rf_wr_en`, `of_f_en`, `z_f_en`, `pc_en` (`pc_sel`=00); `cmp_f_en`=0; total 3 cycles.
- Branch taken and not taken: BEQ `instr`=0xC005.
  - `psr`=0x0040 → `pc_sel`=01 with `pc_en`.
  - `psr`=0x0000 → `pc_sel`=00.
- LOAD with wait states: `instr`=0x4102, `mem_ready` low for 2 cycles in MEM → MEM lasts 3 cycles; `rf_wr_en` with `wb_sel`=01 asserts only on the ready cycle.
- Reset during MEM of a STOR: `reset_n` pulsed low while `mem_wr`=1 → `mem_wr` drops immediately; after release, the first active state is FETCH.
- Illegal/JAL: `instr`=0x4E80.
  - With `CTRL_JAL_EN`: `rf_wr_en`, `wb_sel`=10, `pc_sel`=10.
  - Without: `illegal` pulses and `pc_sel`=00.

Source files
------------

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control state machine for a CR16-style datapath.
// Sequences FETCH -> DECODE -> EXEC (-> MEM for LOAD/STOR) -> FETCH and
// drives the strobes of the processor-register block.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset_n    asynchronous active-low reset (FSM returns to FETCH)
//   instr      current instruction register contents (decoded combinationally)
//   psr        status register; C[0] L[2] F[5] Z[6] N[7]
//   mem_ready  memory handshake; FETCH and MEM hold while it is low
//   instr_en   load instruction register from memory read data
//   pc_en      load the PC
//   pc_sel     PC source: 00 PC+1, 01 PC+sext(instr[7:0]), 10 Rsrc
//   cmp_f_en   enable for L/N flag group
//   of_f_en    enable for F/C flag group
//   z_f_en     enable for Z flag
//   rf_wr_en   register-file write enable
//   wb_sel     write-back source: 00 ALU, 01 memory, 10 PC+1
//   mem_rd     memory read strobe
//   mem_wr     memory write strobe
//   addr_sel   memory address source: 0 PC, 1 Raddr
//   illegal    one-cycle pulse in EXEC for an undecodable instruction
//
// Configuration macro: CTRL_JAL_EN
//   defined   -> op=0100 ext=1000 decodes as JAL (link PC+1, jump to Rsrc)
//   undefined -> that encoding is illegal and executes as a NOP

module ctrl_fsm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic [15:0] psr,
  input  logic        mem_ready,
  output logic        instr_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        cmp_f_en,
  output logic        of_f_en,
  output logic        z_f_en,
  output logic        rf_wr_en,
  output logic [1:0]  wb_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_MEM    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [3:0] op, ext, cond;
  assign op   = instr[15:12];
  assign ext  = instr[7:4];
  assign cond = instr[11:8];

  logic flag_c, flag_l, flag_f, flag_z, flag_n;
  assign flag_c = psr[0];
  assign flag_l = psr[2];
  assign flag_f = psr[5];
  assign flag_z = psr[6];
  assign flag_n = psr[7];

  // Bits the controller never looks at (register numbers / immediates and
  // reserved PSR bits); collected so they are consumed explicitly.
  logic unused_bits;
  assign unused_bits = ^{instr[3:0], psr[15:8], psr[4:3], psr[1]};

  logic is_alu, is_load, is_stor, is_jcond, is_bcond, is_jal, is_nop;
  logic dec_cmp, dec_of, dec_z;
  logic cond_true;

  // Instruction class and flag-group decode. R-type uses ext as the ALU
  // opcode, I-type reuses the same code in op, so both share one table.
  always_comb begin
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_stor  = 1'b0;
    is_jcond = 1'b0;
    is_bcond = 1'b0;
    is_jal   = 1'b0;
    is_nop   = (instr == 16'h0000);
    dec_cmp  = 1'b0;
    dec_of   = 1'b0;
    dec_z    = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF: begin
        case ((op == 4'h0) ? ext : op)
          4'h1, 4'h2, 4'h3: begin
            is_alu = 1'b1;
            dec_z  = 1'b1;
          end
          4'h5, 4'h9: begin
            is_alu = 1'b1;
            dec_of = 1'b1;
            dec_z  = 1'b1;
          end
          4'hB: begin
            is_alu  = 1'b1;
            dec_cmp = 1'b1;
            dec_z   = 1'b1;
          end
          4'hD: is_alu = 1'b1;
          // LUI exists only as an I-type opcode
          4'hF: is_alu = (op == 4'hF);
          default: ;
        endcase
      end
      4'h8: is_alu = 1'b1;
      4'h4: begin
        case (ext)
          4'h0: is_load  = 1'b1;
          4'h4: is_stor  = 1'b1;
          4'hC: is_jcond = 1'b1;
`ifdef CTRL_JAL_EN
          4'h8: is_jal   = 1'b1;
`endif
          default: ;
        endcase
      end
      4'hC: is_bcond = 1'b1;
      default: ;
    endcase
  end

  // Branch/jump condition evaluation against the current PSR.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = flag_z;
      4'h1: cond_true = !flag_z;
      4'h2: cond_true = flag_c;
      4'h3: cond_true = !flag_c;
      4'h4: cond_true = flag_l;
      4'h5: cond_true = !flag_l;
      4'h6: cond_true = flag_n;
      4'h7: cond_true = !flag_n;
      4'h8: cond_true = flag_f;
      4'h9: cond_true = !flag_f;
      4'hA: cond_true = !flag_l && !flag_z;
      4'hB: cond_true = flag_l || flag_z;
      4'hC: cond_true = !flag_n && !flag_z;
      4'hD: cond_true = flag_n || flag_z;
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (is_load || is_stor) ? S_MEM : S_FETCH;
      S_MEM:    if (mem_ready) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so no strobe leaks out of an
  // aborted access before the FSM restarts in FETCH.
  always_comb begin
    instr_en = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 2'b00;
    cmp_f_en = 1'b0;
    of_f_en  = 1'b0;
    z_f_en   = 1'b0;
    rf_wr_en = 1'b0;
    wb_sel   = 2'b00;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    illegal  = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_rd   = 1'b1;
          instr_en = mem_ready;
        end
        S_EXEC: begin
          if (is_alu) begin
            rf_wr_en = 1'b1;
            cmp_f_en = dec_cmp;
            of_f_en  = dec_of;
            z_f_en   = dec_z;
            pc_en    = 1'b1;
          end else if (is_load || is_stor) begin
            // PC advances at the end of MEM instead
          end else if (is_jal) begin
            rf_wr_en = 1'b1;
            wb_sel   = 2'b10;
            pc_en    = 1'b1;
            pc_sel   = 2'b10;
          end else if (is_jcond) begin
            pc_en  = 1'b1;
            pc_sel = cond_true ? 2'b10 : 2'b00;
          end else if (is_bcond) begin
            pc_en  = 1'b1;
            pc_sel = cond_true ? 2'b01 : 2'b00;
          end else begin
            pc_en   = 1'b1;
            illegal = !is_nop;
          end
        end
        S_MEM: begin
          addr_sel = 1'b1;
          mem_rd   = is_load;
          mem_wr   = is_stor;
          if (mem_ready) begin
            rf_wr_en = is_load;
            wb_sel   = is_load ? 2'b01 : 2'b00;
            pc_en    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: scoreboard bench for ctrl_fsm. Each task pushes the expected
// per-cycle output vector (with the inputs for that cycle) into a queue and
// then pops and compares one entry per clock.

module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [15:0] psr = 16'h0000;
  logic        mem_ready = 1'b0;
  logic        instr_en, pc_en, cmp_f_en, of_f_en, z_f_en, rf_wr_en;
  logic        mem_rd, mem_wr, addr_sel, illegal;
  logic [1:0]  pc_sel, wb_sel;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ctrl_fsm dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .psr(psr),
    .mem_ready(mem_ready), .instr_en(instr_en), .pc_en(pc_en),
    .pc_sel(pc_sel), .cmp_f_en(cmp_f_en), .of_f_en(of_f_en),
    .z_f_en(z_f_en), .rf_wr_en(rf_wr_en), .wb_sel(wb_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
    .illegal(illegal)
  );

  // {instr_en, pc_en, pc_sel, cmp, of, z, rf_wr, wb_sel, rd, wr, addr_sel, illegal}
  logic [13:0] obs;
  assign obs = {instr_en, pc_en, pc_sel, cmp_f_en, of_f_en, z_f_en, rf_wr_en,
                wb_sel, mem_rd, mem_wr, addr_sel, illegal};

  function automatic logic [13:0] ov(bit ie, bit pe, logic [1:0] ps, bit c,
                                     bit o, bit z, bit rf, logic [1:0] wb,
                                     bit rd, bit wr, bit as, bit il);
    return {ie, pe, ps, c, o, z, rf, wb, rd, wr, as, il};
  endfunction

  typedef struct {
    logic [15:0] ins;
    logic [15:0] p;
    logic        mr;
    logic [13:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb[$];

  function automatic sb_entry_t mk(logic [15:0] ins, logic [15:0] p, logic mr,
                                   logic [13:0] exp, string tag);
    sb_entry_t e;
    e.ins = ins; e.p = p; e.mr = mr; e.exp = exp; e.tag = tag;
    return e;
  endfunction

  // Push one full instruction: FETCH waits, FETCH, DECODE, EXEC, MEM phase.
  task automatic push_seq(input string tag, input logic [15:0] ins,
                          input logic [15:0] p, input int fwait,
                          input logic [13:0] exec_v, input bit has_mem,
                          input int mwait, input logic [13:0] mwait_v,
                          input logic [13:0] mdone_v);
    for (int i = 0; i < fwait; i++)
      sb.push_back(mk(ins, p, 1'b0, ov(0,0,2'b00,0,0,0,0,2'b00,1,0,0,0), {tag, "/fetch_wait"}));
    sb.push_back(mk(ins, p, 1'b1, ov(1,0,2'b00,0,0,0,0,2'b00,1,0,0,0), {tag, "/fetch"}));
    sb.push_back(mk(ins, p, 1'b1, 14'h0, {tag, "/decode"}));
    sb.push_back(mk(ins, p, 1'b1, exec_v, {tag, "/exec"}));
    if (has_mem) begin
      for (int i = 0; i < mwait; i++)
        sb.push_back(mk(ins, p, 1'b0, mwait_v, {tag, "/mem_wait"}));
      sb.push_back(mk(ins, p, 1'b1, mdone_v, {tag, "/mem_done"}));
    end
  endtask

  task automatic test_reset();
    sb_entry_t e;
    reset_n = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_wr, pc_en, rf_wr_en, illegal, addr_sel} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold: got %b want 00000", {mem_wr, pc_en, rf_wr_en, illegal, addr_sel});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_seq("reset_movi", 16'hD105, 16'h0, 0, ov(0,1,2'b00,0,0,0,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    sb_entry_t e;
    push_seq("add",  16'h0152, 16'h0, 0, ov(0,1,2'b00,0,1,1,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    push_seq("sub",  16'h0192, 16'h0, 0, ov(0,1,2'b00,0,1,1,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    push_seq("cmp",  16'h01B2, 16'h0, 0, ov(0,1,2'b00,1,0,1,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    push_seq("andi", 16'h1105, 16'h0, 1, ov(0,1,2'b00,0,0,1,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    push_seq("shft", 16'h8104, 16'h0, 0, ov(0,1,2'b00,0,0,0,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    push_seq("lui",  16'hF1FF, 16'h0, 0, ov(0,1,2'b00,0,0,0,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    sb_entry_t e;
    logic [13:0] tk_b, tk_j, nt;
    tk_b = ov(0,1,2'b01,0,0,0,0,2'b00,0,0,0,0);
    tk_j = ov(0,1,2'b10,0,0,0,0,2'b00,0,0,0,0);
    nt   = ov(0,1,2'b00,0,0,0,0,2'b00,0,0,0,0);
    push_seq("beq_t",  16'hC005, 16'h0040, 0, tk_b, 0, 0, 14'h0, 14'h0);
    push_seq("beq_nt", 16'hC005, 16'h0000, 0, nt,   0, 0, 14'h0, 14'h0);
    push_seq("bne_t",  16'hC105, 16'h0000, 0, tk_b, 0, 0, 14'h0, 14'h0);
    push_seq("bhi_nt", 16'hCA05, 16'h0004, 0, nt,   0, 0, 14'h0, 14'h0);
    push_seq("bhi_t",  16'hCA05, 16'h0000, 0, tk_b, 0, 0, 14'h0, 14'h0);
    push_seq("juc",    16'h4EC3, 16'h0000, 0, tk_j, 0, 0, 14'h0, 14'h0);
    push_seq("jnever", 16'h4FC3, 16'hFFFF, 0, nt,   0, 0, 14'h0, 14'h0);
    push_seq("jfs",    16'h48C3, 16'h0020, 0, tk_j, 0, 0, 14'h0, 14'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    sb_entry_t e;
    push_seq("load", 16'h4102, 16'h0, 0, 14'h0, 1, 2,
             ov(0,0,2'b00,0,0,0,0,2'b00,1,0,1,0),
             ov(0,1,2'b00,0,0,0,1,2'b01,1,0,1,0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stor_reset();
    sb_entry_t e;
    logic [13:0] sw, sd;
    sw = ov(0,0,2'b00,0,0,0,0,2'b00,0,1,1,0);
    sd = ov(0,1,2'b00,0,0,0,0,2'b00,0,1,1,0);
    push_seq("stor_a", 16'h4143, 16'h0, 0, 14'h0, 1, 1, sw, sd);
    void'(sb.pop_back());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
    // Still in MEM with mem_ready low: strobe must be up, then drop on reset
    total++;
    if (mem_wr !== 1'b1) begin bad++; $display("[TB] FAIL stor_pre_reset: mem_wr got %b want 1", mem_wr); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({mem_wr, addr_sel} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL stor_reset_drop: {mem_wr,addr_sel} got %b want 00", {mem_wr, addr_sel});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_ready = 1'b1;
    push_seq("stor_b", 16'h4143, 16'h0, 0, 14'h0, 1, 0, sw, sd);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal_illegal();
    sb_entry_t e;
`ifdef CTRL_JAL_EN
    push_seq("jal", 16'h4E80, 16'h0, 0, ov(0,1,2'b10,0,0,0,1,2'b10,0,0,0,0), 0, 0, 14'h0, 14'h0);
`else
    push_seq("jal_ill", 16'h4E80, 16'h0, 0, ov(0,1,2'b00,0,0,0,0,2'b00,0,0,0,1), 0, 0, 14'h0, 14'h0);
`endif
    push_seq("op6_ill", 16'h6000, 16'h0, 0, ov(0,1,2'b00,0,0,0,0,2'b00,0,0,0,1), 0, 0, 14'h0, 14'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    sb_entry_t e;
    for (int r = 0; r < 4; r++) begin
      push_seq("b2b_add", 16'h0152, 16'h0, int'($urandom_range(0, 2)),
               ov(0,1,2'b00,0,1,1,1,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
      push_seq("b2b_stor", 16'h4143, 16'h0, int'($urandom_range(0, 2)), 14'h0, 1,
               int'($urandom_range(0, 2)),
               ov(0,0,2'b00,0,0,0,0,2'b00,0,1,1,0),
               ov(0,1,2'b00,0,0,0,0,2'b00,0,1,1,0));
      push_seq("b2b_load", 16'h4102, 16'h0, int'($urandom_range(0, 2)), 14'h0, 1,
               int'($urandom_range(0, 2)),
               ov(0,0,2'b00,0,0,0,0,2'b00,1,0,1,0),
               ov(0,1,2'b00,0,0,0,1,2'b01,1,0,1,0));
      push_seq("b2b_beq", 16'hC005, 16'h0040, 0,
               ov(0,1,2'b01,0,0,0,0,2'b00,0,0,0,0), 0, 0, 14'h0, 14'h0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      instr = e.ins; psr = e.p; mem_ready = e.mr;
      @(negedge clk);
      total++;
      if (obs !== e.exp) begin bad++; $display("[TB] FAIL %s: got %h want %h", e.tag, obs, e.exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_wait();
    test_stor_reset();
    test_jal_illegal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
